// File: rtl/spi_master_if.sv
// Control-side handshake and serial pins of the single-byte SPI master.
// The master modport is the DUT view; the slave modport is the driving side.
interface spi_master_if;
  localparam int unsigned DATA_W = 8;

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              busy;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic              SS_n;

  modport master (
    input  start, tx_data, MISO,
    output rx_data, done, busy, SCLK, MOSI, SS_n
  );

  modport slave (
    output start, tx_data, MISO,
    input  rx_data, done, busy, SCLK, MOSI, SS_n
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first, full duplex.
// One byte per accepted start; done pulses as SS_n rises, then an H-cycle gap.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);
  localparam int unsigned      DATA_W    = 8;
  localparam int unsigned      CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'd7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_tx, w_tx_nxt;
  logic [DATA_W-1:0] r_rx, w_rx_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_mosi, w_mosi_nxt;
  logic              r_ss_n, w_ss_n_nxt;
  logic              r_miso_s1, r_miso_s2;
  logic              w_half_end;

  assign w_half_end = (r_cnt == HALF_LAST);

  // State and output registers; MISO crosses in through two flops
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ss_n    <= w_ss_n_nxt;
      r_miso_s1 <= bus.MISO;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Next state and next register values; every phase lasts CLK_DIV cycles
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = r_busy;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_ss_n_nxt    = r_ss_n;

    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_half_end ? '0 : r_cnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start) begin
          w_tx_nxt    = bus.tx_data;
          w_mosi_nxt  = bus.tx_data[DATA_W-1];
          w_ss_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_bit_nxt   = '0;
          w_rx_nxt    = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_half_end) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        // Sample on the falling SCLK edge and present the next bit at once
        if (w_half_end) begin
          w_rx_nxt    = {r_rx[DATA_W-2:0], r_miso_s2};
          w_sclk_nxt  = 1'b0;
          w_state_nxt = S_LOW;
          if (r_bit != BIT_LAST) begin
            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
            w_mosi_nxt = r_tx[DATA_W-2];
          end
        end
      end
      S_LOW: begin
        if (w_half_end) begin
          if (r_bit == BIT_LAST) begin
            w_ss_n_nxt    = 1'b1;
            w_rx_data_nxt = r_rx;
            w_done_nxt    = 1'b1;
            w_state_nxt   = S_GAP;
          end else begin
            w_sclk_nxt  = 1'b1;
            w_bit_nxt   = r_bit + 3'd1;
            w_state_nxt = S_HIGH;
          end
        end
      end
      S_GAP: begin
        if (w_half_end) begin
          w_busy_nxt  = 1'b0;
          w_mosi_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rx_data = r_rx_data;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.SCLK    = r_sclk;
  assign bus.MOSI    = r_mosi;
  assign bus.SS_n    = r_ss_n;
endmodule
